// File: rtl/spi_memory_cmd_decoder.sv
// spi_memory_cmd_decoder
//   Turns the command/address/data strobes of spi_memory_slave (already in the
//   main_clock domain) into single-beat accesses on a simple req/ack memory
//   port. It also steers the slave's phase sequencing through expect_* and
//   insert_dummy_cycles, and supplies the byte the slave shifts out.
//   Supported commands: 0x02 WRITE, 0x03 READ, 0x0B FAST_READ, 0x05 STATUS,
//   0x9F READ_ID.
//
// Ports
//   main_clock, reset           clock, synchronous active-high reset
//   cmd, cmd_valid              command byte and its level qualifier
//   addr, addr_valid            address and its level qualifier
//   write_data, write_data_valid   written byte, rises once per byte
//   read_data_request           rises when the slave needs the next read byte
//   read_data_captured          rises when the slave has latched read_data
//   operation_in_progress       high while chip select is asserted
//   expect_addr/expect_write/expect_read/insert_dummy_cycles  phase control
//   read_data                   byte for the slave to transmit
//   mem_req/mem_we/mem_addr/mem_wdata  access request, held until mem_ack
//   mem_rdata, mem_ack          read data and one-cycle completion pulse
//   overrun                     sticky: trigger seen while an access was busy
module spi_memory_cmd_decoder #(
  parameter int                      ADDR_BYTES = 3,
  parameter int                      ID_BYTES   = 3,
  parameter logic [8*ID_BYTES-1:0]   ID_VALUE   = 24'hA5C001
) (
  input  logic                    main_clock,
  input  logic                    reset,
  input  logic [7:0]              cmd,
  input  logic                    cmd_valid,
  input  logic [8*ADDR_BYTES-1:0] addr,
  input  logic                    addr_valid,
  input  logic [7:0]              write_data,
  input  logic                    write_data_valid,
  input  logic                    read_data_request,
  input  logic                    read_data_captured,
  input  logic                    operation_in_progress,
  output logic                    expect_addr,
  output logic                    expect_write,
  output logic                    expect_read,
  output logic                    insert_dummy_cycles,
  output logic [7:0]              read_data,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [8*ADDR_BYTES-1:0] mem_addr,
  output logic [7:0]              mem_wdata,
  input  logic [7:0]              mem_rdata,
  input  logic                    mem_ack,
  output logic                    overrun
);

  localparam int AW    = 8 * ADDR_BYTES;
  localparam int IDX_W = (ID_BYTES > 1) ? $clog2(ID_BYTES) : 1;

  localparam logic [7:0] CMD_WRITE     = 8'h02;
  localparam logic [7:0] CMD_READ      = 8'h03;
  localparam logic [7:0] CMD_FAST_READ = 8'h0B;
  localparam logic [7:0] CMD_STATUS    = 8'h05;
  localparam logic [7:0] CMD_READ_ID   = 8'h9F;

  localparam logic [IDX_W-1:0] ID_LAST = IDX_W'(ID_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_ADDR   = 3'd2,
    ST_DATA   = 3'd3,
    ST_STATUS = 3'd4,
    ST_ID     = 3'd5
  } state_t;

  // ID bytes are returned most-significant byte first.
  function automatic logic [7:0] id_byte(input logic [IDX_W-1:0] idx);
    return ID_VALUE[8*(ID_BYTES-1-int'(idx)) +: 8];
  endfunction

  state_t            state_q, state_d;
  logic              addr_valid_prev_q, wdv_prev_q, rdreq_prev_q, capt_prev_q, oip_prev_q;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [7:0]        rbuf_q, rbuf_d;
  logic [IDX_W-1:0]  id_idx_q, id_idx_d;
  logic              overrun_q, overrun_d;

  logic addr_rise_s, wdv_rise_s, rdreq_rise_s, capt_rise_s, oip_rise_s, oip_fall_s;
  logic active_s, addr_cmd_s, busy_s;
  logic prefetch_trig_s, read_trig_s, write_trig_s, any_trig_s;
  logic [AW-1:0] trig_addr_s;

  assign addr_rise_s  = addr_valid & ~addr_valid_prev_q;
  assign wdv_rise_s   = write_data_valid & ~wdv_prev_q;
  assign rdreq_rise_s = read_data_request & ~rdreq_prev_q;
  assign capt_rise_s  = read_data_captured & ~capt_prev_q;
  assign oip_rise_s   = operation_in_progress & ~oip_prev_q;
  assign oip_fall_s   = ~operation_in_progress & oip_prev_q;

  // Outside a recognised chip-select window (including right after a reset
  // that landed mid-transaction) the slave is told nothing.
  assign active_s   = (state_q != ST_IDLE);
  assign addr_cmd_s = (cmd == CMD_WRITE) | (cmd == CMD_READ) | (cmd == CMD_FAST_READ);
  // An ack in the same cycle frees the port for a new trigger.
  assign busy_s     = mem_req_q & ~mem_ack;

  assign prefetch_trig_s = (state_q == ST_ADDR) & addr_rise_s & cmd_valid & (cmd == CMD_READ);
  assign read_trig_s     = (state_q == ST_DATA) & rdreq_rise_s & cmd_valid &
                           ((cmd == CMD_READ) | (cmd == CMD_FAST_READ));
  assign write_trig_s    = (state_q == ST_DATA) & wdv_rise_s & cmd_valid & (cmd == CMD_WRITE);
  assign any_trig_s      = prefetch_trig_s | read_trig_s | write_trig_s;
  // The prefetch fires in the same cycle the pointer is loaded, so use addr directly.
  assign trig_addr_s     = prefetch_trig_s ? addr : ptr_q;

  // Phase control to the slave, combinational so it is ready for the next SCK edge.
  always_comb begin
    expect_addr         = active_s & cmd_valid & addr_cmd_s;
    expect_write        = active_s & cmd_valid & (cmd == CMD_WRITE) & addr_valid;
    expect_read         = active_s & cmd_valid &
                          ((cmd == CMD_STATUS) | (cmd == CMD_READ_ID) |
                           (((cmd == CMD_READ) | (cmd == CMD_FAST_READ)) & addr_valid));
    insert_dummy_cycles = active_s & cmd_valid & (cmd == CMD_FAST_READ);
  end

  // Transmit byte selection: status word, ID byte, or fetched buffer.
  always_comb begin
    read_data = rbuf_q;
    if (active_s && cmd_valid && (cmd == CMD_STATUS)) begin
      read_data = {6'b000000, overrun_q, mem_req_q};
    end else if (active_s && cmd_valid && (cmd == CMD_READ_ID)) begin
      read_data = id_byte(id_idx_q);
    end else begin
      read_data = rbuf_q;
    end
  end

  // Transaction phase sequencing.
  always_comb begin
    state_d = state_q;
    if (!operation_in_progress) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (oip_rise_s) state_d = ST_CMD;
          else            state_d = ST_IDLE;
        end
        ST_CMD: begin
          if (cmd_valid) begin
            case (cmd)
              CMD_WRITE, CMD_READ, CMD_FAST_READ: state_d = ST_ADDR;
              CMD_STATUS:                         state_d = ST_STATUS;
              CMD_READ_ID:                        state_d = ST_ID;
              default:                            state_d = ST_CMD;
            endcase
          end else begin
            state_d = ST_CMD;
          end
        end
        ST_ADDR: begin
          if (addr_rise_s) state_d = ST_DATA;
          else             state_d = ST_ADDR;
        end
        ST_DATA:   state_d = ST_DATA;
        ST_STATUS: state_d = ST_STATUS;
        ST_ID:     state_d = ST_ID;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Memory access issue/retire, pointer, read buffer, ID index and overrun.
  always_comb begin
    ptr_d       = ptr_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rbuf_d      = rbuf_q;
    id_idx_d    = id_idx_q;
    overrun_d   = overrun_q;

    if (!operation_in_progress) begin
      ptr_d       = '0;
      mem_req_d   = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = 8'h00;
      rbuf_d      = 8'h00;
      id_idx_d    = '0;
    end else begin
      if (mem_req_q && mem_ack) begin
        mem_req_d = 1'b0;
        if (!mem_we_q) rbuf_d = mem_rdata;
        else           rbuf_d = rbuf_q;
      end else begin
        mem_req_d = mem_req_q;
      end

      if ((state_q == ST_ADDR) && addr_rise_s) ptr_d = addr;
      else                                     ptr_d = ptr_q;

      if (any_trig_s) begin
        if (busy_s) begin
          overrun_d = 1'b1;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = write_trig_s;
          mem_addr_d = trig_addr_s;
          if (write_trig_s) mem_wdata_d = write_data;
          else              mem_wdata_d = mem_wdata_q;
          ptr_d      = trig_addr_s + AW'(1);
        end
      end else begin
        overrun_d = overrun_q;
      end

      if ((state_q == ST_ID) && capt_rise_s && (id_idx_q < ID_LAST)) id_idx_d = id_idx_q + IDX_W'(1);
      else                                                           id_idx_d = id_idx_q;
    end

    // Reading STATUS acknowledges the overrun once that transaction ends.
    if (oip_fall_s && (state_q == ST_STATUS)) overrun_d = 1'b0;
    else                                      overrun_d = overrun_d;
  end

  // State and datapath registers.
  always_ff @(posedge main_clock) begin
    if (reset) begin
      state_q           <= ST_IDLE;
      addr_valid_prev_q <= 1'b0;
      wdv_prev_q        <= 1'b0;
      rdreq_prev_q      <= 1'b0;
      capt_prev_q       <= 1'b0;
      // Preset high so a chip select already asserted across reset is not
      // mistaken for a new transaction.
      oip_prev_q        <= 1'b1;
      ptr_q             <= '0;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_wdata_q       <= 8'h00;
      rbuf_q            <= 8'h00;
      id_idx_q          <= '0;
      overrun_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_valid_prev_q <= addr_valid;
      wdv_prev_q        <= write_data_valid;
      rdreq_prev_q      <= read_data_request;
      capt_prev_q       <= read_data_captured;
      oip_prev_q        <= operation_in_progress;
      ptr_q             <= ptr_d;
      mem_req_q         <= mem_req_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_wdata_q       <= mem_wdata_d;
      rbuf_q            <= rbuf_d;
      id_idx_q          <= id_idx_d;
      overrun_q         <= overrun_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_memory_cmd_decoder.sv
// Directed bench for spi_memory_cmd_decoder: plays the slave side and a
// hand-driven memory responder, comparing against hand-computed values.
module tb_spi_memory_cmd_decoder;

  logic        main_clock = 1'b0;
  logic        reset;
  logic [7:0]  cmd;
  logic        cmd_valid;
  logic [23:0] addr;
  logic        addr_valid;
  logic [7:0]  write_data;
  logic        write_data_valid;
  logic        read_data_request;
  logic        read_data_captured;
  logic        operation_in_progress;
  logic        expect_addr, expect_write, expect_read, insert_dummy_cycles;
  logic [7:0]  read_data;
  logic        mem_req, mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic        overrun;

  int n_cmp = 0;
  int n_err = 0;

  spi_memory_cmd_decoder dut (
    .main_clock            (main_clock),
    .reset                 (reset),
    .cmd                   (cmd),
    .cmd_valid             (cmd_valid),
    .addr                  (addr),
    .addr_valid            (addr_valid),
    .write_data            (write_data),
    .write_data_valid      (write_data_valid),
    .read_data_request     (read_data_request),
    .read_data_captured    (read_data_captured),
    .operation_in_progress (operation_in_progress),
    .expect_addr           (expect_addr),
    .expect_write          (expect_write),
    .expect_read           (expect_read),
    .insert_dummy_cycles   (insert_dummy_cycles),
    .read_data             (read_data),
    .mem_req               (mem_req),
    .mem_we                (mem_we),
    .mem_addr              (mem_addr),
    .mem_wdata             (mem_wdata),
    .mem_rdata             (mem_rdata),
    .mem_ack               (mem_ack),
    .overrun               (overrun)
  );

  always #5 main_clock = ~main_clock;

  task automatic step();
    @(posedge main_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a request, check it, then ack after dly cycles.
  task automatic serve(input string tag, input logic we, input logic [23:0] a,
                       input logic [7:0] wd, input logic [7:0] rd, input int dly);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_req"}, 32'(mem_req), 32'h1);
    check({tag, "_we"}, 32'(mem_we), 32'(we));
    check({tag, "_addr"}, 32'(mem_addr), 32'(a));
    if (we) check({tag, "_wdata"}, 32'(mem_wdata), 32'(wd));
    for (int i = 1; i < dly; i++) step();
    mem_rdata = rd;
    mem_ack   = 1'b1;
    step();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    check({tag, "_retired"}, 32'(mem_req), 32'h0);
  endtask

  task automatic start_cs(input logic [7:0] c);
    operation_in_progress = 1'b1;
    step();
    step();
    cmd       = c;
    cmd_valid = 1'b1;
    #1;
  endtask

  task automatic end_cs();
    cmd_valid             = 1'b0;
    addr_valid            = 1'b0;
    write_data_valid      = 1'b0;
    read_data_request     = 1'b0;
    read_data_captured    = 1'b0;
    operation_in_progress = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic [7:0] exp_id [3];
    exp_id = '{8'hC0, 8'h01, 8'h01};

    reset = 1'b1; cmd = 8'h00; cmd_valid = 1'b0; addr = 24'h0; addr_valid = 1'b0;
    write_data = 8'h00; write_data_valid = 1'b0; read_data_request = 1'b0;
    read_data_captured = 1'b0; operation_in_progress = 1'b0; mem_rdata = 8'h00; mem_ack = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_rdata", 32'(read_data), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_exp_addr", 32'(expect_addr), 32'h0);

    // WRITE 02 000010 AA BB
    start_cs(8'h02);
    check("wr_exp_addr", 32'(expect_addr), 32'h1);
    check("wr_exp_write_early", 32'(expect_write), 32'h0);
    step();
    addr = 24'h000010; addr_valid = 1'b1;
    #1;
    check("wr_exp_write", 32'(expect_write), 32'h1);
    step();
    step();
    check("wr_no_prefetch", 32'(mem_req), 32'h0);
    write_data = 8'hAA; write_data_valid = 1'b1;
    serve("wr0", 1'b1, 24'h000010, 8'hAA, 8'h00, 1);
    write_data_valid = 1'b0;
    step();
    write_data = 8'hBB; write_data_valid = 1'b1;
    serve("wr1", 1'b1, 24'h000011, 8'hBB, 8'h00, 2);
    end_cs();
    check("wr_cs_addr_clr", 32'(mem_addr), 32'h0);

    // READ 03 000100, ack delay 3
    start_cs(8'h03);
    check("rd_exp_read_early", 32'(expect_read), 32'h0);
    step();
    addr = 24'h000100; addr_valid = 1'b1;
    #1;
    check("rd_exp_read", 32'(expect_read), 32'h1);
    check("rd_no_dummy", 32'(insert_dummy_cycles), 32'h0);
    serve("rd0", 1'b0, 24'h000100, 8'h00, 8'h11, 3);
    check("rd_byte0", 32'(read_data), 32'h11);
    read_data_request = 1'b1;
    serve("rd1", 1'b0, 24'h000101, 8'h00, 8'h22, 3);
    check("rd_byte1", 32'(read_data), 32'h22);
    read_data_request = 1'b0;
    step();
    read_data_request = 1'b1;
    serve("rd2", 1'b0, 24'h000102, 8'h00, 8'h33, 3);
    check("rd_byte2", 32'(read_data), 32'h33);
    end_cs();

    // FAST_READ 0B FFFFFF with wrap
    start_cs(8'h0B);
    check("fr_dummy", 32'(insert_dummy_cycles), 32'h1);
    check("fr_exp_addr", 32'(expect_addr), 32'h1);
    step();
    addr = 24'hFFFFFF; addr_valid = 1'b1;
    step();
    step();
    check("fr_no_prefetch", 32'(mem_req), 32'h0);
    check("fr_exp_read", 32'(expect_read), 32'h1);
    read_data_request = 1'b1;
    serve("fr0", 1'b0, 24'hFFFFFF, 8'h00, 8'h5A, 1);
    check("fr_byte0", 32'(read_data), 32'h5A);
    read_data_request = 1'b0;
    step();
    read_data_request = 1'b1;
    serve("fr1", 1'b0, 24'h000000, 8'h00, 8'h6B, 2);
    check("fr_byte1", 32'(read_data), 32'h6B);
    end_cs();

    // READ_ID 9F, four bytes
    start_cs(8'h9F);
    step();
    step();
    check("id_exp_read", 32'(expect_read), 32'h1);
    check("id_exp_addr", 32'(expect_addr), 32'h0);
    check("id_byte0", 32'(read_data), 32'hA5);
    for (int k = 0; k < 3; k++) begin
      read_data_captured = 1'b1;
      step();
      read_data_captured = 1'b0;
      step();
      check($sformatf("id_byte%0d", k + 1), 32'(read_data), 32'(exp_id[k]));
    end
    check("id_no_req", 32'(mem_req), 32'h0);
    end_cs();

    // Overrun: ack-coincident trigger accepted, busy trigger dropped
    start_cs(8'h02);
    step();
    addr = 24'h000020; addr_valid = 1'b1;
    step();
    step();
    write_data = 8'h12; write_data_valid = 1'b1;
    step();
    check("ov_req0", 32'(mem_req), 32'h1);
    check("ov_addr0", 32'(mem_addr), 32'h20);
    write_data_valid = 1'b0;
    step();
    write_data = 8'h34; write_data_valid = 1'b1; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("ov_req1", 32'(mem_req), 32'h1);
    check("ov_addr1", 32'(mem_addr), 32'h21);
    check("ov_wdata1", 32'(mem_wdata), 32'h34);
    check("ov_not_yet", 32'(overrun), 32'h0);
    write_data_valid = 1'b0;
    step();
    write_data = 8'h56; write_data_valid = 1'b1;
    step();
    step();
    check("ov_set", 32'(overrun), 32'h1);
    check("ov_addr_kept", 32'(mem_addr), 32'h21);
    check("ov_wdata_kept", 32'(mem_wdata), 32'h34);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("ov_retired", 32'(mem_req), 32'h0);
    end_cs();
    check("ov_sticky", 32'(overrun), 32'h1);

    // STATUS 05 clears overrun on CS release
    start_cs(8'h05);
    check("st_exp_read", 32'(expect_read), 32'h1);
    step();
    step();
    check("st_byte", 32'(read_data), 32'h02);
    end_cs();
    check("st_ov_clr", 32'(overrun), 32'h0);

    // Reset in the middle of an access
    start_cs(8'h03);
    step();
    addr = 24'h000040; addr_valid = 1'b1;
    step();
    step();
    check("rs_req_before", 32'(mem_req), 32'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rs_req", 32'(mem_req), 32'h0);
    check("rs_exp_read", 32'(expect_read), 32'h0);
    check("rs_exp_addr", 32'(expect_addr), 32'h0);
    check("rs_rdata", 32'(read_data), 32'h0);
    mem_rdata = 8'hEE; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0; mem_rdata = 8'h00;
    check("rs_late_ack_rdata", 32'(read_data), 32'h0);
    check("rs_late_ack_req", 32'(mem_req), 32'h0);
    end_cs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
